// File: rtl/etapa2.sv
// -----------------------------------------------------------------------------
// etapa2 : second stage of the pipelined signed divider
//          (32-bit dividend / 16-bit divisor -> 16-bit quotient).
//
// Takes the registered operands and sign flags from stage 1. It turns both
// operands into unsigned magnitudes, works out the quotient and remainder
// signs, and flags divide-by-zero and quotient-magnitude overflow. Everything
// is registered for the iterative-subtraction stages that follow.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   goIn             stage-1 go; load enable for all data registers
//   divisorIn        two's-complement divisor   (AnchoDv+1 bits)
//   dividendIn       two's-complement dividend  (AnchoDd+1 bits)
//   negDivisorIn     divisor sign from stage 1
//   negDividendIn    dividend sign from stage 1
//   DivisorNoCeroIn  divisor is nonzero
//   goOut            goIn delayed one cycle
//   magDivisorOut    |divisor|
//   magDividendOut   |dividend|
//   negQuotientOut   quotient sign
//   negRemainderOut  remainder sign
//   divByZeroOut     divisor was zero
//   overflowOut      quotient magnitude does not fit AnchoQ+1 bits
//   errorOut         divByZeroOut | overflowOut
// -----------------------------------------------------------------------------
module etapa2 #(
    parameter int unsigned AnchoDv = 15,
    parameter int unsigned AnchoDd = 31,
    parameter int unsigned AnchoQ  = 15,
    parameter int unsigned HiDdMin = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               goIn,
    input  logic [AnchoDv:0]   divisorIn,
    input  logic [AnchoDd:0]   dividendIn,
    input  logic               negDivisorIn,
    input  logic               negDividendIn,
    input  logic               DivisorNoCeroIn,
    output logic               goOut,
    output logic [AnchoDv:0]   magDivisorOut,
    output logic [AnchoDd:0]   magDividendOut,
    output logic               negQuotientOut,
    output logic               negRemainderOut,
    output logic               divByZeroOut,
    output logic               overflowOut,
    output logic               errorOut
);

    localparam logic [AnchoDv:0] ONE_DV = {{AnchoDv{1'b0}}, 1'b1};
    localparam logic [AnchoDd:0] ONE_DD = {{AnchoDd{1'b0}}, 1'b1};

    logic               go_q;
    logic [AnchoDv:0]   magDv_q,  magDv_d;
    logic [AnchoDd:0]   magDd_q,  magDd_d;
    logic               negQ_q,   negQ_d;
    logic               negR_q,   negR_d;
    logic               dbz_q,    dbz_d;
    logic               ovf_q,    ovf_d;
    logic               err_q,    err_d;

    // Sign comes from the stage-1 flags, not the data MSB. Negation is at full
    // width, so the most-negative value maps onto its unsigned weight.
    always_comb begin
        magDv_d = negDivisorIn  ? (~divisorIn  + ONE_DV) : divisorIn;
        magDd_d = negDividendIn ? (~dividendIn + ONE_DD) : dividendIn;
        negQ_d  = negDividendIn ^ negDivisorIn;
        negR_d  = negDividendIn;
        dbz_d   = ~DivisorNoCeroIn;
        // If the dividend's high half is >= the divisor, the quotient cannot
        // fit in AnchoQ+1 bits. A zero divisor is reported only as divide-by-zero.
        ovf_d   = DivisorNoCeroIn && (magDd_d[AnchoDd:HiDdMin] >= magDv_d);
        err_d   = dbz_d | ovf_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            go_q    <= 1'b0;
            magDv_q <= '0;
            magDd_q <= '0;
            negQ_q  <= 1'b0;
            negR_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            go_q <= goIn;
            if (goIn) begin
                magDv_q <= magDv_d;
                magDd_q <= magDd_d;
                negQ_q  <= negQ_d;
                negR_q  <= negR_d;
                dbz_q   <= dbz_d;
                ovf_q   <= ovf_d;
                err_q   <= err_d;
            end
        end
    end

    assign goOut           = go_q;
    assign magDivisorOut   = magDv_q;
    assign magDividendOut  = magDd_q;
    assign negQuotientOut  = negQ_q;
    assign negRemainderOut = negR_q;
    assign divByZeroOut    = dbz_q;
    assign overflowOut     = ovf_q;
    assign errorOut        = err_q;

endmodule

// File: tb/tb_etapa2.sv
// -----------------------------------------------------------------------------
// tb_etapa2 : self-checking bench for etapa2. The reference model works on
// integer values: magnitude as 2^W - x, overflow as (|dividend| / 2^16) >= |divisor|.
// -----------------------------------------------------------------------------
module tb_etapa2;

    logic        clk = 1'b0;
    logic        reset;
    logic        goIn;
    logic [15:0] divisorIn;
    logic [31:0] dividendIn;
    logic        negDivisorIn, negDividendIn, DivisorNoCeroIn;
    logic        goOut;
    logic [15:0] magDivisorOut;
    logic [31:0] magDividendOut;
    logic        negQuotientOut, negRemainderOut, divByZeroOut, overflowOut, errorOut;

    etapa2 #(.AnchoDv(15), .AnchoDd(31), .AnchoQ(15), .HiDdMin(16)) dut (
        .clk(clk), .reset(reset), .goIn(goIn),
        .divisorIn(divisorIn), .dividendIn(dividendIn),
        .negDivisorIn(negDivisorIn), .negDividendIn(negDividendIn),
        .DivisorNoCeroIn(DivisorNoCeroIn),
        .goOut(goOut), .magDivisorOut(magDivisorOut), .magDividendOut(magDividendOut),
        .negQuotientOut(negQuotientOut), .negRemainderOut(negRemainderOut),
        .divByZeroOut(divByZeroOut), .overflowOut(overflowOut), .errorOut(errorOut)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // expected state
    logic        e_go, e_nq, e_nr, e_dbz, e_ovf, e_err;
    logic [15:0] e_mdv;
    logic [31:0] e_mdd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":goOut"},  {31'd0, goOut},           {31'd0, e_go});
        chk({ctx, ":magDv"},  {16'd0, magDivisorOut},   {16'd0, e_mdv});
        chk({ctx, ":magDd"},  magDividendOut,           e_mdd);
        chk({ctx, ":negQ"},   {31'd0, negQuotientOut},  {31'd0, e_nq});
        chk({ctx, ":negR"},   {31'd0, negRemainderOut}, {31'd0, e_nr});
        chk({ctx, ":dbz"},    {31'd0, divByZeroOut},    {31'd0, e_dbz});
        chk({ctx, ":ovf"},    {31'd0, overflowOut},     {31'd0, e_ovf});
        chk({ctx, ":err"},    {31'd0, errorOut},        {31'd0, e_err});
    endtask

    task automatic model_clear();
        e_go = 0; e_nq = 0; e_nr = 0; e_dbz = 0; e_ovf = 0; e_err = 0;
        e_mdv = '0; e_mdd = '0;
    endtask

    // Reference: integer arithmetic on the captured inputs.
    task automatic model_edge();
        longint unsigned dv, dd, mdv, mdd;
        if (!reset) begin
            model_clear();
            return;
        end
        e_go = goIn;
        if (goIn) begin
            dv  = longint'(divisorIn);
            dd  = longint'(dividendIn);
            mdv = negDivisorIn  ? ((64'h1_0000 - dv) % 64'h1_0000)         : dv;
            mdd = negDividendIn ? ((64'h1_0000_0000 - dd) % 64'h1_0000_0000) : dd;
            e_mdv = mdv[15:0];
            e_mdd = mdd[31:0];
            e_nq  = negDividendIn != negDivisorIn;
            e_nr  = negDividendIn;
            e_dbz = !DivisorNoCeroIn;
            e_ovf = DivisorNoCeroIn && ((mdd / 64'h1_0000) >= mdv);
            e_err = e_dbz || e_ovf;
        end
    endtask

    task automatic drive(input logic g, input logic [15:0] dv, input logic [31:0] dd,
                         input logic ndv, input logic ndd, input logic nc);
        goIn = g; divisorIn = dv; dividendIn = dd;
        negDivisorIn = ndv; negDividendIn = ndd; DivisorNoCeroIn = nc;
    endtask

    task automatic drive_rand(input logic g);
        logic [15:0] dv;
        logic [31:0] dd;
        int unsigned mode;
        dv = 16'($urandom);
        dd = $urandom;
        mode = $urandom_range(0, 4);
        if (mode == 0) dv = 16'd0;
        if (mode == 1) dd = {16'($urandom_range(0, 3)), 16'($urandom)};
        if (mode == 2) dv = 16'h8000;
        if (mode == 3) dd = 32'h8000_0000;
        // mostly consistent flags, occasionally inconsistent with the MSB
        drive(g, dv, dd,
              ($urandom_range(0, 7) == 0) ? 1'($urandom) : dv[15],
              ($urandom_range(0, 7) == 0) ? 1'($urandom) : dd[31],
              ($urandom_range(0, 7) == 0) ? 1'($urandom) : (dv != 16'd0));
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        drive_rand(1'b1);
        #1;
        check_all("rst_async");
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b1);
            step("rst_hold");
        end
        reset = 1'b1;
        drive(1'b0, 16'h1234, 32'h5678_9abc, 1'b1, 1'b1, 1'b1);
        step("post_rst_idle");
        step("post_rst_idle2");

        drive(1'b1, 16'hFFFD, 32'h0000_0064, 1'b1, 1'b0, 1'b1);
        step("neg3_pos100");

        drive(1'b1, 16'h8000, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
        step("most_neg");

        drive(1'b1, 16'h0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        step("div_zero");

        // just below and at the overflow boundary
        drive(1'b1, 16'h0010, 32'h000F_FFFF, 1'b0, 1'b0, 1'b1);
        step("ovf_below");
        drive(1'b1, 16'h0010, 32'h0010_0000, 1'b0, 1'b0, 1'b1);
        step("ovf_at");

        // A, idle with changed inputs, B
        drive(1'b1, 16'h0007, 32'h0000_1000, 1'b0, 1'b0, 1'b1);
        step("hold_A");
        drive(1'b0, 16'hFFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        step("hold_idle");
        drive(1'b1, 16'hFFF0, 32'hFFFF_0000, 1'b1, 1'b1, 1'b1);
        step("hold_B");
        drive(1'b0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        step("hold_B_out");

        for (int i = 0; i < 300; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            step("rand");
        end

        // asynchronous reset between edges with live outputs
        drive(1'b1, 16'h8000, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
        step("pre_mid_rst");
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_all("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 16'h0003, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
        step("after_mid_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/etapa2.md
Name: etapa2

Overview:
- Second stage of the pipelined signed divider (32-bit dividend / 16-bit divisor, 16-bit quotient).
- Consumes the registered outputs of stage 1: go, divisor, dividend, negDivisor, negDividend, DivisorNoCero.
- Converts both operands to unsigned magnitudes and derives result signs and exception flags.
- Registers everything for the iterative-subtraction stages downstream.

Parameters:
- AnchoDv, 15, MSB index of divisor (divisor width = AnchoDv+1)
- AnchoDd, 31, MSB index of dividend (dividend width = AnchoDd+1)
- AnchoQ, 15, MSB index of quotient; must equal AnchoDv
- HiDdMin, 16, LSB index of dividend high half used for overflow check; equals AnchoQ+1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- goIn  input  1  stage-1 go; enable for all data registers
- divisorIn  input  AnchoDv+1  two's-complement divisor from stage 1
- dividendIn  input  AnchoDd+1  two's-complement dividend from stage 1
- negDivisorIn  input  1  divisor sign bit from stage 1
- negDividendIn  input  1  dividend sign bit from stage 1
- DivisorNoCeroIn  input  1  divisor-nonzero flag from stage 1
- goOut  output  1  go delayed one cycle
- magDivisorOut  output  AnchoDv+1  unsigned |divisor|
- magDividendOut  output  AnchoDd+1  unsigned |dividend|
- negQuotientOut  output  1  quotient sign
- negRemainderOut  output  1  remainder sign
- divByZeroOut  output  1  divisor was zero
- overflowOut  output  1  quotient magnitude cannot fit AnchoQ+1 bits
- errorOut  output  1  divByZero OR overflow

Behaviour:
- Reset: reset low clears every output register to 0 immediately, independent of clk. Release takes effect on the next rising edge.
- go register: loads goIn on every edge (always enabled). Latency 1 cycle.
- All other registers load only on edges where goIn=1. Otherwise they hold their value, so data stays valid until the next go.
- Magnitude: mag = neg ? (~x + 1) : x, computed at full operand width, no extension. Sign is taken from the negDivisorIn/negDividendIn ports, not recomputed from the data MSB.
  - Most-negative values map to the unsigned weight: 0x8000 gives mag 0x8000; 0x80000000 gives mag 0x80000000.
- Signs:
  - negQuotientOut = negDividendIn XOR negDivisorIn.
  - negRemainderOut = negDividendIn.
  - If the dividend is zero, the signs are still computed as above; the downstream stage handles -0.
- divByZeroOut = ~DivisorNoCeroIn.
- overflowOut = DivisorNoCeroIn AND (magDividend[AnchoDd:HiDdMin] >= magDivisor), as an unsigned compare of combinational magnitudes. It is forced to 0 when the divisor is zero.
- The signed-range check (e.g. +32768 quotient) is not done here; it belongs to the final stage.
- errorOut = divByZero OR overflow, registered in the same cycle as its sources. Never asserted while goOut=0 after reset until the first go.
- Back-to-back goIn pulses: each cycle captures new operands; throughput 1 per cycle, no stall.
- Reset mid-operation: in-flight data is discarded and goOut drops the same instant.
- goIn asserted in the cycle reset deasserts: captured only if reset is released before that rising edge.

Test Plan:
- Reset low with random inputs and clock toggling -> all outputs 0. Release, goIn=0 -> outputs stay 0.
- goIn=1, divisor=0xFFFD (-3), dividend=0x00000064 (+100), negDv=1, negDd=0, NoCero=1 -> next cycle:
  - goOut=1, magDv=0x0003, magDd=0x00000064
  - negQ=1, negR=0, overflow=0, error=0
- divisor=0x8000, dividend=0x80000000, both neg, NoCero=1 -> magDv=0x8000, magDd=0x80000000, negQ=0, negR=1; high half 0x8000 >= 0x8000 -> overflow=1, error=1.
- divisor=0, dividend=0x12345678, NoCero=0 -> divByZero=1, overflow=0, error=1.
- Operand A on cycle n, goIn=0 on n+1 with changed inputs, operand B on n+2 -> outputs hold A through n+2 with goOut=0 at n+2. B appears at n+3.
- Assert reset between two edges while goOut=1 and outputs nonzero -> all outputs 0 before the next edge.
